// File: rtl/apb_pkg.sv
// apb_pkg: shared types and widths for the APB master bridge
package apb_pkg;
  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;
  localparam int PORT_W = 3;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  typedef struct packed {
    logic we;
    logic [PORT_W-1:0] port;
    logic [APB_ADDR_W-1:0] offset;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps a core byte address to peripheral port and offset
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int NUM_PORTS = 6
) (
  input  logic [31:0]           addr,
  output logic                  hit,
  output logic [PORT_W-1:0]     port,
  output logic [APB_ADDR_W-1:0] offset
);
  logic unused_bit15;
  assign unused_bit15 = addr[15];
  assign hit = addr[31:16] == BASE_ADDR[31:16] && {29'd0, addr[14:12]} < NUM_PORTS;
  assign port = addr[14:12] + 3'd1;
  assign offset = addr[11:0];
endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready core request to APB SETUP/ACCESS bridge with timeout
module apb_master
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int NUM_PORTS = 6,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr_out,
  output logic                  en_out,
  output logic [PORT_W-1:0]     sel_port,
  output logic [APB_ADDR_W-1:0] addr_out,
  output logic [APB_DATA_W-1:0] data_out,
  input  logic                  ready_in,
  input  logic [APB_DATA_W-1:0] readdata_in,
  input  logic                  pslverr_in
);
  apb_state_e state, nxt;
  apb_req_t req_q, dec_req, cur;
  logic hit, accept, timeout, busy;
  logic [PORT_W-1:0] port;
  logic [APB_ADDR_W-1:0] offset;
  logic [7:0] cnt;
  apb_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_PORTS(NUM_PORTS)) u_dec (
    .addr(req_addr), .hit(hit), .port(port), .offset(offset)
  );
  assign req_ready = state == IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign timeout = cnt == 8'(TIMEOUT - 1);
  assign dec_req = '{we: req_we, port: port, offset: offset, wdata: req_wdata};
  // In IDLE the live decode drives the SETUP registers directly; afterwards the captured copy holds
  assign cur = state == IDLE ? dec_req : req_q;
  assign busy = nxt == SETUP || nxt == ACCESS;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE   ? (accept ? (hit ? SETUP : RESP) : IDLE) :
          state == SETUP  ? ACCESS :
          state == ACCESS ? (ready_in || timeout ? RESP : ACCESS) : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      req_q <= '0;
      cnt <= '0;
      sel_port <= '0;
      wr_out <= 1'b0;
      en_out <= 1'b0;
      addr_out <= '0;
      data_out <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      req_q <= cur;
      cnt <= state == ACCESS && nxt == ACCESS ? cnt + 8'd1 : 8'd0;
      sel_port <= busy ? cur.port : '0;
      wr_out <= busy && cur.we;
      en_out <= nxt == ACCESS;
      addr_out <= nxt == SETUP ? cur.offset : addr_out;
      data_out <= nxt == SETUP ? cur.wdata : data_out;
      rsp_valid <= nxt == RESP;
      rsp_err <= nxt == RESP && (state == IDLE || !ready_in || pslverr_in);
      rsp_rdata <= nxt == RESP && state == ACCESS && ready_in && !pslverr_in && !req_q.we ? readdata_in : '0;
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized checks of apb_master against a transaction-level model
module tb_apb_master;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, ready_in = 1'b0, pslverr_in = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, readdata_in = '0;
  logic req_ready, rsp_valid, rsp_err, wr_out, en_out;
  logic [31:0] rsp_rdata, data_out;
  logic [2:0] sel_port;
  logic [11:0] addr_out;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  apb_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wr_out(wr_out), .en_out(en_out), .sel_port(sel_port), .addr_out(addr_out),
    .data_out(data_out), .ready_in(ready_in), .readdata_in(readdata_in), .pslverr_in(pslverr_in)
  );

  // waits < 0 means the slave never answers; otherwise ready comes on ACCESS cycle index waits
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] sdata, input logic serr);
    logic hit, tmo, eerr, active;
    logic [2:0] port;
    logic [31:0] erd;
    int lat, acc;
    hit = addr[31:16] == 16'h4000 && addr[14:12] < 3'd6;
    port = addr[14:12] + 3'd1;
    tmo = hit && (waits < 0 || waits >= TO);
    lat = !hit ? 1 : tmo ? TO + 2 : waits + 3;
    eerr = !hit || tmo || serr;
    erd = (eerr || we) ? 32'd0 : sdata;
    acc = 0;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%b want=1", req_ready); end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      active = hit && k < lat;
      total++;
      if (sel_port !== (active ? port : 3'd0)) begin bad++; $display("FAIL sel_port k=%0d got=%0d want=%0d", k, sel_port, active ? port : 3'd0); end
      total++;
      if (en_out !== (active && k >= 2)) begin bad++; $display("FAIL en_out k=%0d got=%b want=%b", k, en_out, active && k >= 2); end
      total++;
      if (wr_out !== (active && we)) begin bad++; $display("FAIL wr_out k=%0d got=%b want=%b", k, wr_out, active && we); end
      if (active) begin
        total++;
        if (addr_out !== addr[11:0]) begin bad++; $display("FAIL addr_out k=%0d got=%h want=%h", k, addr_out, addr[11:0]); end
        total++;
        if (data_out !== wdata) begin bad++; $display("FAIL data_out k=%0d got=%h want=%h", k, data_out, wdata); end
      end
      total++;
      if (rsp_valid !== (k == lat)) begin bad++; $display("FAIL rsp_valid k=%0d got=%b want=%b", k, rsp_valid, k == lat); end
      if (k == lat) begin
        total++;
        if (rsp_rdata !== erd) begin bad++; $display("FAIL rsp_rdata got=%h want=%h", rsp_rdata, erd); end
        total++;
        if (rsp_err !== eerr) begin bad++; $display("FAIL rsp_err got=%b want=%b", rsp_err, eerr); end
      end
      total++;
      if (req_ready !== (k > lat)) begin bad++; $display("FAIL req_ready k=%0d got=%b want=%b", k, req_ready, k > lat); end
      if (en_out) begin ready_in = acc == waits; acc++; end else ready_in = 1'($urandom);
      pslverr_in = (en_out && ready_in) ? serr : 1'($urandom);
      readdata_in = (en_out && ready_in) ? sdata : $urandom;
    end
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++;
    if ({rsp_valid, rsp_err, wr_out, en_out, sel_port, addr_out, data_out, rsp_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b%b%b%b %h %h %h %h want=all zero",
                      rsp_valid, rsp_err, wr_out, en_out, sel_port, addr_out, data_out, rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'h4000_2010, 32'hDEAD_BEEF, 0, $urandom, 1'b0);
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 32'h4000_5FFC, $urandom, 3, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_decode_err();
    run_txn(1'b0, 32'h4000_6000, $urandom, 0, $urandom, 1'b0);
    run_txn(1'b0, 32'h5000_0000, $urandom, 0, $urandom, 1'b0);
    run_txn(1'b1, 32'h4000_7ABC, $urandom, 0, $urandom, 1'b0);
    run_txn(1'b0, 32'h4000_8123, $urandom, 1, 32'hCAFE_0001, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h4000_0004, $urandom, -1, $urandom, 1'b0);
    run_txn(1'b0, 32'h4000_1008, $urandom, TO - 1, 32'hA5A5_5A5A, 1'b0);
    run_txn(1'b1, 32'h4000_4000, 32'h0BAD_F00D, TO - 2, $urandom, 1'b0);
  endtask

  task automatic test_slverr();
    run_txn(1'b0, 32'h4000_3100, $urandom, 0, 32'hFFFF_FFFF, 1'b1);
    run_txn(1'b1, 32'h4000_0200, 32'h1111_2222, 2, $urandom, 1'b1);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_3000; ready_in = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (en_out !== 1'b1) begin bad++; $display("FAIL mid_access_en got=%b want=1", en_out); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({en_out, sel_port, rsp_valid, req_ready} !== 6'b0) begin
      bad++; $display("FAIL mid_reset got en=%b sel=%0d rsp_valid=%b req_ready=%b want=0", en_out, sel_port, rsp_valid, req_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL stale_rsp cycle=%0d got=%b want=0", i, rsp_valid); end
    end
    run_txn(1'b0, 32'h4000_3044, $urandom, 1, 32'h7777_0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] hi;
      hi = $urandom_range(0, 4) == 0 ? 16'($urandom) : 16'h4000;
      run_txn(1'($urandom), {hi, 16'($urandom)}, $urandom, int'($urandom_range(0, 19)),
              $urandom, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_err();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
